// File: rtl/brew_pkg.sv
// Shared types and the recipe ROM for the brew sequencer.
// A recipe row is a list of {valve, ticks} steps terminated by the first zero-duration entry.
package brew_pkg;

    localparam int ROM_TYPES = 8;
    localparam int ROM_STEPS = 4;
    localparam int ING_W     = 3;
    localparam int ROM_DUR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DISPENSE,
        DONE
    } state_t;

    typedef struct packed {
        logic [ING_W-1:0]     ing;
        logic [ROM_DUR_W-1:0] dur;
    } step_t;

    localparam step_t NO_STEP = '0;

    localparam step_t RECIPE [ROM_TYPES][ROM_STEPS] = '{
        '{NO_STEP, NO_STEP, NO_STEP, NO_STEP},
        '{step_t'{3'd0, 4'd3}, step_t'{3'd1, 4'd2}, NO_STEP, NO_STEP},
        '{step_t'{3'd0, 4'd2}, step_t'{3'd1, 4'd2}, step_t'{3'd2, 4'd1}, NO_STEP},
        '{step_t'{3'd0, 4'd1}, step_t'{3'd1, 4'd1}, step_t'{3'd2, 4'd1}, step_t'{3'd3, 4'd1}},
        '{NO_STEP, NO_STEP, NO_STEP, NO_STEP},
        '{NO_STEP, NO_STEP, NO_STEP, NO_STEP},
        '{NO_STEP, NO_STEP, NO_STEP, NO_STEP},
        '{NO_STEP, NO_STEP, NO_STEP, NO_STEP}
    };

    // Out-of-table lookups read as an empty step, so callers never index past the ROM.
    function automatic step_t rom_entry(input int unsigned t, input int unsigned s);
        if (t < ROM_TYPES && s < ROM_STEPS)
            return RECIPE[t[$clog2(ROM_TYPES)-1:0]][s[$clog2(ROM_STEPS)-1:0]];
        return NO_STEP;
    endfunction

    function automatic logic [ROM_DUR_W-1:0] rom_dur(input int unsigned t, input int unsigned s);
        step_t e;
        e = rom_entry(t, s);
        return e.dur;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits one tick every TICK_DIV enabled clocks.
// clear restarts the count so each step begins on a full tick period.
module tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/brew_sequencer.sv
// Recipe sequencer: latches a drink type, then walks its ROM steps opening one valve per step
// for dur prescaled ticks. cancel aborts from any busy state.
import brew_pkg::*;

module brew_sequencer #(
    parameter int N_ING     = 4,
    parameter int TYPE_W    = 3,
    parameter int MAX_STEPS = 4,
    parameter int DUR_W     = 4,
    parameter int TICK_DIV  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TYPE_W-1:0]    c_type,
    input  logic                 ok,
    input  logic                 cancel,
    output logic [N_ING-1:0]     ingredients,
    output logic [TYPE_W-1:0]    ing_type,
    output logic [((MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1)-1:0] step_idx,
    output logic [DUR_W-1:0]     time_left,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 aborted
);

    localparam int SIDX_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    state_t              state, state_n;
    logic [TYPE_W-1:0]   type_n;
    logic [SIDX_W-1:0]   idx_n;
    logic [DUR_W-1:0]    left_n;
    logic [ING_W-1:0]    cur_ing, ing_n;
    logic                err_n, abort_n;
    logic                presc_clr, tick, last;
    step_t               cur_e;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clr),
        .en    (state == DISPENSE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ing_type  <= '0;
            step_idx  <= '0;
            time_left <= '0;
            cur_ing   <= '0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            ing_type  <= type_n;
            step_idx  <= idx_n;
            time_left <= left_n;
            cur_ing   <= ing_n;
            err       <= err_n;
            aborted   <= abort_n;
        end
    end

    always_comb begin
        state_n   = state;
        type_n    = ing_type;
        idx_n     = step_idx;
        left_n    = time_left;
        ing_n     = cur_ing;
        err_n     = 1'b0;
        abort_n   = 1'b0;
        presc_clr = 1'b0;
        cur_e     = rom_entry(32'(ing_type), 32'(step_idx));
        last      = (step_idx == SIDX_W'(MAX_STEPS - 1));

        case (state)
            IDLE: begin
                if (ok && !cancel) begin
                    if (c_type != '0 && rom_dur(32'(c_type), 0) != '0) begin
                        type_n  = c_type;
                        idx_n   = '0;
                        state_n = LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                left_n    = DUR_W'(cur_e.dur);
                ing_n     = cur_e.ing;
                presc_clr = 1'b1;
                state_n   = DISPENSE;
            end
            DISPENSE: begin
                // The final tick both zeroes time_left and leaves DISPENSE, closing the valve.
                if (tick && time_left != '0) begin
                    left_n = time_left - DUR_W'(1);
                    if (time_left == DUR_W'(1)) begin
                        if (last || rom_dur(32'(ing_type), 32'(step_idx) + 1) == '0) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = step_idx + SIDX_W'(1);
                            state_n = LOAD;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                type_n  = '0;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase

        if (cancel && state != IDLE) begin
            state_n = IDLE;
            type_n  = '0;
            idx_n   = '0;
            left_n  = '0;
            ing_n   = '0;
            abort_n = 1'b1;
        end
    end

    // Valve codes beyond the output width decode to no valve at all.
    always_comb begin
        ingredients = '0;
        if (state == DISPENSE && 32'(cur_ing) < N_ING)
            ingredients = N_ING'(1) << cur_ing;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) && !cancel;

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Parametrised recipe sequencer that is the next generation of the coffee-maker control FSM.
- On an `ok` request it latches the drink type and walks a ROM recipe of up to MAX_STEPS steps. Each step opens one ingredient valve for a programmed duration.
- Timing uses an internal prescaled down-counter instead of an external timer handshake.
- Sits between the front-panel input logic and the valve drivers.

Parameters:
- N_ING, 4, number of ingredient valves (one-hot output width).
- TYPE_W, 3, drink-type code width; code 0 means "none".
- MAX_STEPS, 4, maximum steps per recipe.
- DUR_W, 4, step duration width, in ticks.
- TICK_DIV, 1000, clocks per duration tick; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- c_type  in  TYPE_W  requested drink type.
- ok  in  1  start request, level-sampled in IDLE.
- cancel  in  1  abort the current brew.
- ingredients  out  N_ING  one-hot valve enables; all zero when no valve is open.
- ing_type  out  TTYPE_W  latched drink type, 0 when idle.
- step_idx  out  clog2(MAX_STEPS)  current step number.
- time_left  out  DUR_W  ticks remaining in the current step.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse when a start request has an invalid type.
- aborted  out  1  one-cycle pulse when a brew is cancelled.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n low forces state IDLE and drives all outputs and counters to 0 immediately, including mid-brew.
- States: IDLE, LOAD, DISPENSE, DONE.
- IDLE, start: ok=1, cancel=0, and c_type is a valid recipe (nonzero, and step-0 duration nonzero). Next cycle: latch c_type into ing_type, set step_idx=0, enter LOAD.
- IDLE, invalid start: ok=1, cancel=0, and c_type is invalid. Pulse err for one cycle, stay in IDLE.
- IDLE, simultaneous ok and cancel: cancel wins; no start, no err.
- LOAD (1 cycle, valves off): read ROM entry {ing, dur} for (ing_type, step_idx). Set time_left=dur and clear the prescaler; next state DISPENSE.
- DISPENSE: ingredients = one-hot(ing). The prescaler counts 0..TICK_DIV-1; on wrap, time_left decrements.
  - When time_left reaches 0 the valve closes that same edge, so the valve is open for exactly dur*TICK_DIV cycles.
  - On exit, if step_idx==MAX_STEPS-1 or the next entry's dur==0, go to DONE.
  - Otherwise increment step_idx and go to LOAD.
- DONE (1 cycle): done=1, valves off. Next state IDLE; ing_type and step_idx clear to 0.
- cancel=1 in LOAD, DISPENSE or DONE:
  - Next edge: valves off, state IDLE, ing_type/step_idx/time_left cleared, aborted pulsed.
  - done is not pulsed; cancel beats normal completion in the same cycle.
- ok while busy is ignored; changes on c_type after latching are ignored.
- Invariants: ingredients is never multi-hot. ROM `ing` values of N_ING or above are treated as a zero valve mask, and the step still times out normally.
- Arithmetic: prescaler width is clog2(TICK_DIV). time_left never underflows, and tick counting is non-wrapping.

Decomposition:
- Package brew_pkg holds:
  - state enum;
  - step struct {ing, dur};
  - recipe ROM constant array, indexed [type][step].
- Default recipes:
  - type1 = {ing0,3},{ing1,2}
  - type2 = {ing0,2},{ing1,2},{ing2,1}
  - type3 = {ing0,1},{ing1,1},{ing2,1},{ing3,1}
  - types 4–7 = all dur 0, i.e. invalid.
- Sub-module tick_prescaler (counter + tick output, synchronous clear), instantiated once.

Test Plan:
- Reset mid-brew: TICK_DIV=4, start type1, drop rst_n during DISPENSE -> outputs 0 asynchronously; IDLE after release.
- Type1 normal: TICK_DIV=4, ok pulse with c_type=1 ->
  - busy next edge;
  - ingredients=0001 for exactly 12 cycles, then a 1-cycle gap;
  - ingredients=0010 for 8 cycles;
  - done pulses once, busy low the following cycle.
- Invalid type: c_type=0 and c_type=5 with ok -> err one cycle each, busy stays 0, ingredients stays 0.
- Cancel: start type3, assert cancel at step_idx=2 mid-DISPENSE -> next edge ingredients=0, aborted=1, done never asserted; ok with cancel both high in IDLE -> no start.
- ok ignored while busy: start type2, pulse ok with c_type=1 during step 1 -> ing_type remains 2; full 3-step sequence 8/8/4 cycles completes.
- MAX_STEPS boundary: type3 -> four steps, each 4 cycles; done follows step_idx=3 without reading past the table.
